bram_search_ctrl: RTL and testbench

- Initiator/controller for the single-port search BRAM (cs/oe/we/address/din/dout interface, registered read data).
- Host side loads words into the RAM, then starts a search for a key. The controller reads addresses 0..DEPTH-1 sequentially and compares each word against the key.
- Reports found flag, lowest matching address, and a done pulse. Owns every RAM control pin.

---
 rtl/bram_search_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_bram_search_ctrl.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_search_ctrl.sv
// bram_search_ctrl
// Host-facing controller for a single-port search BRAM with registered read
// data. The host loads words through the controller, then starts a search;
// the controller walks addresses 0..DEPTH-1 two cycles per word (issue, then
// compare) and reports found / lowest matching position / done.
//
// Optional feature macro: MATCH_COUNT_EN
//   defined   - always scans all DEPTH words and exposes match_count
//   undefined - stops at the first match, no match_count port

module bram_search_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 8,
    parameter int DEPTH         = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [ADDRESS_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    key,
    output logic                     busy,
    output logic                     done,
    output logic                     found,
    output logic [ADDRESS_WIDTH-1:0] position,
`ifdef MATCH_COUNT_EN
    output logic [ADDRESS_WIDTH:0]   match_count,
`endif
    output logic                     ram_cs,
    output logic                     ram_oe,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0]    ram_din,
    input  logic [DATA_WIDTH-1:0]    ram_dout
);

    typedef enum logic [2:0] {
        IDLE,
        WRITE,
        RD_ISSUE,
        RD_CMP,
        DONE
    } state_t;

    localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDR = ADDRESS_WIDTH'(DEPTH - 1);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_ONE  = ADDRESS_WIDTH'(1);

    state_t                   state;
    state_t                   state_next;
    logic [DATA_WIDTH-1:0]    key_q;
    logic [DATA_WIDTH-1:0]    key_next;
    logic                     found_next;
    logic [ADDRESS_WIDTH-1:0] position_next;
    logic                     cs_next;
    logic                     oe_next;
    logic                     we_next;
    logic [ADDRESS_WIDTH-1:0] addr_next;
    logic [DATA_WIDTH-1:0]    din_next;
    logic                     is_match;
    logic                     scan_end;

`ifdef MATCH_COUNT_EN
    localparam logic [ADDRESS_WIDTH:0] COUNT_ONE = (ADDRESS_WIDTH + 1)'(1);
    logic [ADDRESS_WIDTH:0] count_next;
`endif

    // Read data is only meaningful in RD_CMP, where the address is still held
    // from the issue cycle, so the comparison is a plain equality on dout.
    assign is_match = (ram_dout == key_q);

    // With match counting every word must be visited; otherwise the first hit
    // ends the scan early.
`ifdef MATCH_COUNT_EN
    assign scan_end = (ram_address == LAST_ADDR);
`else
    assign scan_end = (ram_address == LAST_ADDR) || is_match;
`endif

    // Status flags are pure decodes of the state register.
    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // State register plus every registered output; reset clears it all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            key_q       <= '0;
            found       <= 1'b0;
            position    <= '0;
            ram_cs      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_we      <= 1'b0;
            ram_address <= '0;
            ram_din     <= '0;
`ifdef MATCH_COUNT_EN
            match_count <= '0;
`endif
        end else begin
            state       <= state_next;
            key_q       <= key_next;
            found       <= found_next;
            position    <= position_next;
            ram_cs      <= cs_next;
            ram_oe      <= oe_next;
            ram_we      <= we_next;
            ram_address <= addr_next;
            ram_din     <= din_next;
`ifdef MATCH_COUNT_EN
            match_count <= count_next;
`endif
        end
    end

    // Next-state logic: writes win over a simultaneous start in IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (wr_en) begin
                    state_next = WRITE;
                end else if (start) begin
                    state_next = RD_ISSUE;
                end
            end
            WRITE:    state_next = wr_en ? WRITE : IDLE;
            RD_ISSUE: state_next = RD_CMP;
            RD_CMP:   state_next = scan_end ? DONE : RD_ISSUE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Next values of the registered outputs; RAM strobes default low and the
    // address/data/results hold unless a state explicitly changes them.
    always_comb begin
        key_next      = key_q;
        found_next    = found;
        position_next = position;
        cs_next       = 1'b0;
        oe_next       = 1'b0;
        we_next       = 1'b0;
        addr_next     = ram_address;
        din_next      = ram_din;
`ifdef MATCH_COUNT_EN
        count_next    = match_count;
`endif
        case (state)
            IDLE, WRITE: begin
                if (wr_en) begin
                    cs_next   = 1'b1;
                    we_next   = 1'b1;
                    addr_next = wr_addr;
                    din_next  = wr_data;
                end else if (state == IDLE && start) begin
                    key_next      = key;
                    found_next    = 1'b0;
                    position_next = '0;
`ifdef MATCH_COUNT_EN
                    count_next    = '0;
`endif
                    cs_next       = 1'b1;
                    oe_next       = 1'b1;
                    addr_next     = '0;
                end
            end
            RD_CMP: begin
                if (is_match && !found) begin
                    found_next    = 1'b1;
                    position_next = ram_address;
                end
`ifdef MATCH_COUNT_EN
                if (is_match) begin
                    count_next = match_count + COUNT_ONE;
                end
`endif
                if (!scan_end) begin
                    cs_next   = 1'b1;
                    oe_next   = 1'b1;
                    addr_next = ram_address + ADDR_ONE;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_bram_search_ctrl.sv
// tb_bram_search_ctrl
// Self-checking bench for bram_search_ctrl with a behavioural single-port
// RAM (registered read data). Search expectations are queued when a start is
// issued and checked by an independent monitor when done pulses.
// Build with MATCH_COUNT_EN defined to exercise the match counting variant.

module tb_bram_search_ctrl;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 8;

    logic          clk;
    logic          rst_n;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          start;
    logic [DW-1:0] key;
    logic          busy;
    logic          done;
    logic          found;
    logic [AW-1:0] position;
`ifdef MATCH_COUNT_EN
    logic [AW:0]   match_count;
`endif
    logic          ram_cs;
    logic          ram_oe;
    logic          ram_we;
    logic [AW-1:0] ram_address;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    typedef struct {
        logic          found;
        logic [AW-1:0] position;
        logic [AW:0]   count;
        int            doneEdge;
    } exp_t;

    exp_t          sbQ[$];
    logic [DW-1:0] mem [256];
    logic [DW-1:0] burstData [8] = '{8'd5, 8'd9, 8'd2, 8'd7, 8'd2, 8'd0, 8'd1, 8'd3};
    int            vecCount  = 0;
    int            missCount = 0;
    int            edgeCount = 0;
    int            weCount   = 0;
    int            doneCount = 0;

    bram_search_ctrl #(
        .DATA_WIDTH   (DW),
        .ADDRESS_WIDTH(AW),
        .DEPTH        (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .key        (key),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .position   (position),
`ifdef MATCH_COUNT_EN
        .match_count(match_count),
`endif
        .ram_cs     (ram_cs),
        .ram_oe     (ram_oe),
        .ram_we     (ram_we),
        .ram_address(ram_address),
        .ram_din    (ram_din),
        .ram_dout   (ram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter used to measure search latency.
    always @(posedge clk) edgeCount <= edgeCount + 1;

    // Behavioural single-port RAM with registered read data; counts write strobes.
    always @(posedge clk) begin
        if (ram_cs === 1'b1 && ram_we === 1'b1) begin
            mem[ram_address] <= ram_din;
            weCount <= weCount + 1;
        end
        if (ram_cs === 1'b1 && ram_oe === 1'b1) begin
            ram_dout <= mem[ram_address];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vecCount++;
        if (actual !== expected) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            doneCount++;
            if (sbQ.size() == 0) begin
                vecCount++;
                missCount++;
                $display("[TB] FAIL unexpectedDone: got done=1, expected no done at edge %0d", edgeCount);
            end else begin
                e = sbQ.pop_front();
                checkOutput("found", found, e.found);
                checkOutput("position", position, e.position);
                checkOutput("doneEdge", edgeCount, e.doneEdge);
`ifdef MATCH_COUNT_EN
                checkOutput("matchCount", match_count, e.count);
`endif
            end
        end
    end

    // Loads burstData into addresses 0..7, one write strobe per cycle.
    task automatic writeBurst();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                checkOutput("burstWe", ram_we, 1);
                checkOutput("burstAddr", ram_address, i - 1);
            end
            wr_en   = 1'b1;
            wr_addr = AW'(i);
            wr_data = burstData[i];
        end
        @(negedge clk);
        checkOutput("burstWe", ram_we, 1);
        checkOutput("burstAddr", ram_address, 7);
        wr_en = 1'b0;
        @(negedge clk);
        checkOutput("burstEndWe", ram_we, 0);
        checkOutput("burstEndBusy", busy, 0);
    endtask

    // Issues one search, queues its expected result and follows the address walk.
    task automatic applyStimulus(input logic [DW-1:0] k, input logic expFound,
                                 input logic [AW-1:0] expPos, input logic [AW:0] expCount,
                                 input bit interfere);
        int lat;
        int n;
`ifdef MATCH_COUNT_EN
        lat = 2 * DEPTH;
`else
        lat = expFound ? 2 * int'(expPos) + 2 : 2 * DEPTH;
`endif
        @(negedge clk);
        start = 1'b1;
        key   = k;
        sbQ.push_back('{expFound, expPos, expCount, edgeCount + 1 + lat});
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            checkOutput("addrSeq", ram_address, i / 2);
            checkOutput("csSeq", ram_cs, (i % 2 == 0) ? 1 : 0);
            if (interfere && i == 3) begin
                wr_en   = 1'b1;
                wr_addr = '0;
                wr_data = k;
                start   = 1'b1;
            end
            if (interfere && i == 5) begin
                wr_en = 1'b0;
                start = 1'b0;
            end
        end
        n = 0;
        while (sbQ.size() != 0 && n < 8) begin
            @(negedge clk);
            n++;
        end
        checkOutput("doneSeen", sbQ.size(), 0);
        if (sbQ.size() != 0) sbQ.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] simulation time limit reached");
    end

    initial begin : stimulus
        int savedWe;
        int savedDone;

        // Reset with write and start requests active: nothing may reach the RAM.
        rst_n   = 1'b0;
        wr_en   = 1'b1;
        start   = 1'b1;
        wr_addr = 8'h03;
        wr_data = 8'h55;
        key     = 8'h09;
        repeat (2) @(negedge clk);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstDone", done, 0);
        checkOutput("rstFound", found, 0);
        checkOutput("rstPosition", position, 0);
        checkOutput("rstCs", ram_cs, 0);
        checkOutput("rstOe", ram_oe, 0);
        checkOutput("rstWe", ram_we, 0);
        checkOutput("rstAddr", ram_address, 0);
        checkOutput("rstDin", ram_din, 0);
`ifdef MATCH_COUNT_EN
        checkOutput("rstCount", match_count, 0);
`endif
        checkOutput("rstWrites", weCount, 0);
        wr_en = 1'b0;
        start = 1'b0;
        rst_n = 1'b1;

        // Load {5,9,2,7,2,0,1,3} and confirm the RAM contents.
        writeBurst();
        for (int i = 0; i < 8; i++) begin
            checkOutput("memLoad", mem[i], burstData[i]);
        end
        checkOutput("loadWrites", weCount, 8);

        // Searches on the loaded data.
        applyStimulus(8'd2, 1'b1, 8'd2, 9'd2, 1'b0);
        applyStimulus(8'd4, 1'b0, 8'd0, 9'd0, 1'b0);
        applyStimulus(8'd5, 1'b1, 8'd0, 9'd1, 1'b0);
        applyStimulus(8'd3, 1'b1, 8'd7, 9'd1, 1'b0);

        // Write and start together in IDLE: the write wins, the start is dropped.
        savedDone = doneCount;
        @(negedge clk);
        wr_en   = 1'b1;
        start   = 1'b1;
        wr_addr = 8'd5;
        wr_data = 8'hAA;
        key     = 8'h09;
        @(negedge clk);
        checkOutput("contWe", ram_we, 1);
        checkOutput("contOe", ram_oe, 0);
        checkOutput("contAddr", ram_address, 5);
        wr_en = 1'b0;
        start = 1'b0;
        @(negedge clk);
        checkOutput("contWeEnd", ram_we, 0);
        checkOutput("contBusyEnd", busy, 0);
        repeat (20) @(negedge clk);
        checkOutput("contNoSearch", doneCount, savedDone);
        checkOutput("contMem", mem[5], 8'hAA);
        applyStimulus(8'hAA, 1'b1, 8'd5, 9'd1, 1'b0);

        // Write and start requests while busy must be ignored.
        savedWe = weCount;
        applyStimulus(8'd4, 1'b0, 8'd0, 9'd0, 1'b1);
        checkOutput("busyNoWrite", weCount, savedWe);
        checkOutput("busyMemKeep", mem[0], 8'd5);
        applyStimulus(8'd2, 1'b1, 8'd2, 9'd2, 1'b0);

        // Reset while comparing address 3 (which holds the key): abort, no done.
        savedDone = doneCount;
        @(negedge clk);
        start = 1'b1;
        key   = 8'd7;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
        end
        checkOutput("preRstAddr", ram_address, 3);
        checkOutput("preRstCs", ram_cs, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("abortBusy", busy, 0);
        checkOutput("abortDone", done, 0);
        checkOutput("abortFound", found, 0);
        checkOutput("abortAddr", ram_address, 0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checkOutput("abortNoDone", doneCount, savedDone);

        // Same search runs normally after the abort; RAM contents survive.
        applyStimulus(8'd7, 1'b1, 8'd3, 9'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
